booth_mac_accumulator: RTL and testbench
========================================

Name: booth_mac_accumulator

Overview:
Downstream consumer and sequencer for the 8x8 unsigned radix-4 Booth multiplier.
- Accepts a stream of operand pairs over valid/ready and drives them onto the multiplier x/y inputs.
- Tracks each pair through the multiplier's registered-input latency and accumulates the 16-bit products into a wide sum.
- Presents one dot-product result per packet, delimited by in_last, on a valid/ready output.

Parameters:
- MUL_LAT, 1: cycles from the x/y sampling edge to a valid p. Legal range 1..4.
- ACC_W, 24: accumulator and out_sum width. Must be at least 16.
- CNT_W, 8: width of out_count.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept a pair.
- in_x  in  8  multiplicand, unsigned.
- in_y  in  8  multiplier, unsigned.
- in_last  in  1  marks the final pair of a packet.
- mul_x  out  8  to the multiplier x input.
- mul_y  out  8  to the multiplier y input.
- mul_p  in  16  product from the multiplier.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_sum  out  ACC_W  accumulated sum.
- out_count  out  CNT_W  number of products in the packet, modulo 2^CNT_W.
- out_ovf  out  1  sticky: the sum exceeded the ACC_W range during the packet.

Behaviour:
- Reset (rst=0, async): state=ACCUM, acc=0, cnt=0, ovf=0, tag pipe cleared. Outputs: in_ready=1, out_valid=0, out_sum=0, out_count=0, out_ovf=0.
- mul_x/mul_y = in_x/in_y, combinational and unconditional. The multiplier samples every cycle; non-fired slots are ignored via tags.
- Fire = in_valid & in_ready. On fire, a tag {valid=1, last=in_last} enters a MUL_LAT-deep shift register; otherwise {0,0} enters.
- A tag exiting the pipe with valid=1 is aligned with mul_p in that cycle. At the closing edge: acc <= acc + mul_p (ACC_W+1-bit add), cnt <= cnt+1.
- Carry out of ACC_W sets ovf, which stays sticky until the packet is consumed.
- FSM, three states:
  - ACCUM: in_ready=1. A fire with in_last=1 moves to DRAIN.
  - DRAIN: in_ready=0. When the exiting tag has last=1, its product is added and the next state is OUTPUT.
  - OUTPUT: out_valid=1; out_sum/out_count/out_ovf hold steady. When out_ready=1: acc, cnt and ovf clear and the state returns to ACCUM.
- Latency: out_valid rises MUL_LAT+1 cycles after the in_last handshake edge.
- Throughput: one pair per cycle within a packet. A new packet cannot start before the previous result is consumed, so there are no bubbles inside a packet.
- Boundaries:
  - Single-pair packet (in_last on the first fire) is legal.
  - in_valid held while in_ready=0: no fire, and no tag enters.
  - out_ready high on the first out_valid cycle: one-cycle OUTPUT, and in_ready=1 on the next cycle.
  - cnt wraps at 2^CNT_W.
  - out_valid must not drop without out_ready.
  - Reset mid-packet or in DRAIN: partial sum and in-flight tags are discarded, with no output.

Optional Feature:
- SATURATE_EN defined: on carry out, acc is clamped to 2^ACC_W-1 and held there for the rest of the packet; ovf is still set.
- SATURATE_EN undefined: the sum wraps modulo 2^ACC_W and ovf is set.

Decomposition:
- Package booth_mac_pkg holds:
  - state enum {ACCUM, DRAIN, OUTPUT};
  - localparams OP_W=8, PROD_W=16;
  - the MUL_LAT legal-range constant.
- Sub-module booth_mac_tag_pipe: the parameterised {valid,last} delay line of depth MUL_LAT, also reset by the active-low async rst.
- FSM and accumulator live in the top module.

Test Plan:
- Single pair x=255, y=255, last=1 (MUL_LAT=1) -> out_valid 2 cycles after the handshake; out_sum=65025, out_count=1, out_ovf=0.
- Back-to-back packet (3,4),(5,6),(255,255 last) -> out_sum=65067, out_count=3. in_ready=0 from DRAIN until out_ready is accepted.
- Overflow with ACC_W=17, three x (255,255) -> out_sum=64003 and out_ovf=1 without SATURATE_EN; out_sum=131071 and out_ovf=1 with SATURATE_EN.
- Backpressure: out_ready=0 for 5 cycles -> out_valid and out_sum stable, in_ready=0. out_ready=1 -> next-cycle in_ready=1, and the next packet (2,2 last) gives out_sum=4.
- Gaps: in_valid toggled 1,0,0,1(last) with (10,10),(x,x),(x,x),(20,20) -> out_sum=500, out_count=2.
- Reset asserted in DRAIN after (100,100) -> out_valid stays 0, state=ACCUM. The next packet (1,1 last) gives out_sum=1.

Source files
------------

// File: rtl/booth_mac_pkg.sv
// booth_mac_pkg: shared types and constants for the Booth multiplier MAC accumulator
package booth_mac_pkg;
    typedef enum logic [1:0] {ACCUM, DRAIN, OUTPUT} state_t;
    localparam int OP_W        = 8;
    localparam int PROD_W      = 16;
    localparam int MUL_LAT_MIN = 1;
    localparam int MUL_LAT_MAX = 4;
endpackage

// File: rtl/booth_mac_accumulator_if.sv
// booth_mac_accumulator_if: operand stream, multiplier link and result stream bundle
//   in_valid/in_ready/in_x/in_y/in_last : operand pair stream into the accumulator
//   mul_x/mul_y/mul_p                   : multiplier operands out, product back
//   out_valid/out_ready/out_sum/out_count/out_ovf : per-packet result stream
//   slave  : accumulator side
//   master : producer / multiplier / consumer side
interface booth_mac_accumulator_if
    import booth_mac_pkg::*;
#(
    parameter int ACC_W = 24,
    parameter int CNT_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [OP_W-1:0]   in_x;
    logic [OP_W-1:0]   in_y;
    logic              in_last;
    logic [OP_W-1:0]   mul_x;
    logic [OP_W-1:0]   mul_y;
    logic [PROD_W-1:0] mul_p;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_sum;
    logic [CNT_W-1:0]  out_count;
    logic              out_ovf;

    modport slave (
        input  in_valid, in_x, in_y, in_last, mul_p, out_ready,
        output in_ready, mul_x, mul_y, out_valid, out_sum, out_count, out_ovf
    );

    modport master (
        output in_valid, in_x, in_y, in_last, mul_p, out_ready,
        input  in_ready, mul_x, mul_y, out_valid, out_sum, out_count, out_ovf
    );
endinterface

// File: rtl/booth_mac_tag_pipe.sv
// booth_mac_tag_pipe: {valid,last} delay line matching the multiplier latency
//   clk          : clock, rising edge
//   rst          : asynchronous active-low reset, clears every stage
//   in_v / in_l  : tag entering this cycle
//   out_v / out_l: tag aligned with the multiplier product this cycle
module booth_mac_tag_pipe #(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic in_v,
    input  logic in_l,
    output logic out_v,
    output logic out_l
);
    logic [DEPTH-1:0] v;
    logic [DEPTH-1:0] l;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v <= '0;
            l <= '0;
        end else begin
            v[0] <= in_v;
            l[0] <= in_l;
            for (int i = 1; i < DEPTH; i++) begin
                v[i] <= v[i-1];
                l[i] <= l[i-1];
            end
        end
    end

    assign out_v = v[DEPTH-1];
    assign out_l = l[DEPTH-1];
endmodule

// File: rtl/booth_mac_accumulator.sv
// booth_mac_accumulator: sequences operand pairs into a Booth multiplier and accumulates per-packet dot products
//   clk : clock, rising edge
//   rst : asynchronous active-low reset
//   bus : booth_mac_accumulator_if.slave (operand stream, multiplier link, result stream)
//   SATURATE_EN : when defined, the sum clamps at 2^ACC_W-1 on overflow instead of wrapping
module booth_mac_accumulator
    import booth_mac_pkg::*;
#(
    parameter int MUL_LAT = 1,
    parameter int ACC_W   = 24,
    parameter int CNT_W   = 8
) (
    input logic clk,
    input logic rst,
    booth_mac_accumulator_if.slave bus
);
    if (MUL_LAT < MUL_LAT_MIN || MUL_LAT > MUL_LAT_MAX) begin : g_lat_check
        $error("booth_mac_accumulator: MUL_LAT out of range");
    end

    state_t           state, state_d;
    logic [ACC_W-1:0] acc, acc_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic             ovf, ovf_d;
    logic             fire, tag_v, tag_l, clr;
    logic [ACC_W:0]   sum;

    // The multiplier samples every cycle; only fired slots carry a valid tag.
    assign bus.mul_x = bus.in_x;
    assign bus.mul_y = bus.in_y;

    booth_mac_tag_pipe #(.DEPTH(MUL_LAT)) u_tags (
        .clk   (clk),
        .rst   (rst),
        .in_v  (fire),
        .in_l  (fire & bus.in_last),
        .out_v (tag_v),
        .out_l (tag_l)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ACCUM;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else begin
            state <= state_d;
            acc   <= acc_d;
            cnt   <= cnt_d;
            ovf   <= ovf_d;
        end
    end

    always_comb begin
        bus.in_ready  = state == ACCUM;
        bus.out_valid = state == OUTPUT;
        fire          = bus.in_valid & bus.in_ready;
        clr           = state == OUTPUT && bus.out_ready;
        sum           = {1'b0, acc} + (ACC_W+1)'(bus.mul_p);
        state_d       = (state == ACCUM && fire && bus.in_last) ? DRAIN  :
                        (state == DRAIN && tag_v && tag_l)      ? OUTPUT :
                        clr                                     ? ACCUM  : state;
        cnt_d         = clr ? '0 : tag_v ? cnt + 1'b1 : cnt;
        ovf_d         = clr ? 1'b0 : ovf | (tag_v & sum[ACC_W]);
`ifdef SATURATE_EN
        // Once saturated the sum is pinned until the packet is consumed.
        acc_d         = clr ? '0 : !tag_v ? acc : (sum[ACC_W] | ovf) ? '1 : sum[ACC_W-1:0];
`else
        acc_d         = clr ? '0 : tag_v ? sum[ACC_W-1:0] : acc;
`endif
    end

    assign bus.out_sum   = acc;
    assign bus.out_count = cnt;
    assign bus.out_ovf   = ovf;
endmodule

// File: tb/tb_booth_mac_accumulator.sv
// tb_booth_mac_accumulator: directed bench for booth_mac_accumulator with a one-cycle multiplier model
module tb_booth_mac_accumulator;
    localparam int ACC_W = 17;
    localparam int CNT_W = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_vec = 0;
    int   n_bad = 0;
    logic [ACC_W-1:0] held_sum;

    always #5 clk = ~clk;

    booth_mac_accumulator_if #(.ACC_W(ACC_W), .CNT_W(CNT_W)) bus ();

    booth_mac_accumulator #(.MUL_LAT(1), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Registered-input multiplier with one cycle of latency.
    always @(posedge clk) bus.mul_p <= 16'(bus.mul_x) * 16'(bus.mul_y);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] x, input logic [7:0] y, input logic last);
        bus.in_valid = v;
        bus.in_x     = x;
        bus.in_y     = y;
        bus.in_last  = last;
        tick();
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic wait_out(input string tag);
        for (int i = 0; i < 20 && !bus.out_valid; i++) tick();
        chk(tag, 32'(bus.out_valid), 1);
    endtask

    task automatic consume(input string tag);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk({tag, "_in_ready"}, 32'(bus.in_ready), 1);
        chk({tag, "_out_valid"}, 32'(bus.out_valid), 0);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_x      = '0;
        bus.in_y      = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        bus.mul_p     = '0;
        repeat (2) tick();
        chk("rst_in_ready", 32'(bus.in_ready), 1);
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_out_sum", 32'(bus.out_sum), 0);
        chk("rst_out_count", 32'(bus.out_count), 0);
        chk("rst_out_ovf", 32'(bus.out_ovf), 0);
        rst = 1'b1;
        tick();

        // Single pair: handshake cycle k, result visible in cycle k+2.
        drive(1'b1, 8'd255, 8'd255, 1'b1);
        idle();
        chk("single_valid_k1", 32'(bus.out_valid), 0);
        chk("single_ready_k1", 32'(bus.in_ready), 0);
        tick();
        chk("single_valid_k2", 32'(bus.out_valid), 1);
        chk("single_sum", 32'(bus.out_sum), 65025);
        chk("single_count", 32'(bus.out_count), 1);
        chk("single_ovf", 32'(bus.out_ovf), 0);
        consume("single");

        // Back-to-back packet then output backpressure with in_valid held.
        drive(1'b1, 8'd3, 8'd4, 1'b0);
        drive(1'b1, 8'd5, 8'd6, 1'b0);
        drive(1'b1, 8'd255, 8'd255, 1'b1);
        chk("b2b_drain_ready", 32'(bus.in_ready), 0);
        drive(1'b1, 8'd9, 8'd9, 1'b0);
        wait_out("b2b_valid");
        chk("b2b_sum", 32'(bus.out_sum), 65067);
        chk("b2b_count", 32'(bus.out_count), 3);
        held_sum = bus.out_sum;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_valid", 32'(bus.out_valid), 1);
            chk("bp_sum", 32'(bus.out_sum), 32'(held_sum));
            chk("bp_in_ready", 32'(bus.in_ready), 0);
        end
        chk("bp_count", 32'(bus.out_count), 3);
        idle();
        consume("bp");
        drive(1'b1, 8'd2, 8'd2, 1'b1);
        idle();
        wait_out("after_bp_valid");
        chk("after_bp_sum", 32'(bus.out_sum), 4);
        consume("after_bp");

        // Overflow with a 17-bit accumulator.
        drive(1'b1, 8'd255, 8'd255, 1'b0);
        drive(1'b1, 8'd255, 8'd255, 1'b0);
        drive(1'b1, 8'd255, 8'd255, 1'b1);
        idle();
        wait_out("ovf_valid");
`ifdef SATURATE_EN
        chk("ovf_sum", 32'(bus.out_sum), 131071);
`else
        chk("ovf_sum", 32'(bus.out_sum), 64003);
`endif
        chk("ovf_flag", 32'(bus.out_ovf), 1);
        chk("ovf_count", 32'(bus.out_count), 3);
        consume("ovf");
        chk("ovf_cleared", 32'(bus.out_ovf), 0);

        // Gaps inside a packet.
        drive(1'b1, 8'd10, 8'd10, 1'b0);
        drive(1'b0, 8'd77, 8'd77, 1'b0);
        drive(1'b0, 8'd77, 8'd77, 1'b1);
        drive(1'b1, 8'd20, 8'd20, 1'b1);
        idle();
        wait_out("gap_valid");
        chk("gap_sum", 32'(bus.out_sum), 500);
        chk("gap_count", 32'(bus.out_count), 2);
        consume("gap");

        // Reset while draining discards the packet.
        drive(1'b1, 8'd100, 8'd100, 1'b1);
        idle();
        #2 rst = 1'b0;
        #1;
        chk("rstd_valid", 32'(bus.out_valid), 0);
        chk("rstd_in_ready", 32'(bus.in_ready), 1);
        chk("rstd_sum", 32'(bus.out_sum), 0);
        tick();
        #2 rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rstd_no_out", 32'(bus.out_valid), 0);
        end
        drive(1'b1, 8'd1, 8'd1, 1'b1);
        idle();
        wait_out("post_rst_valid");
        chk("post_rst_sum", 32'(bus.out_sum), 1);
        chk("post_rst_count", 32'(bus.out_count), 1);
        consume("post_rst");

        // Count wraps at 256: 257 products of 1.
        for (int i = 0; i < 256; i++) drive(1'b1, 8'd1, 8'd1, 1'b0);
        drive(1'b1, 8'd1, 8'd1, 1'b1);
        idle();
        wait_out("wrap_valid");
        chk("wrap_sum", 32'(bus.out_sum), 257);
        chk("wrap_count", 32'(bus.out_count), 1);
        consume("wrap");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
